// File: rtl/fp16_pkg.sv
// Shared binary16 field layout, constants and operand unpacking for the fp16 arithmetic units.
package fp16_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int BIAS     = 15;
  localparam int SIG_W    = FRAC_W + 1;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp16_unpacked_t;

  // Subnormals and zero get effective exponent 1 with a clear implicit bit.
  function automatic fp16_unpacked_t fp16_unpack(input logic [15:0] v);
    fp16_unpacked_t u;
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e         = v[SIGN_BIT-1 -: EXP_W];
    f         = v[FRAC_W-1:0];
    u.sign    = v[SIGN_BIT];
    u.exp     = (e == '0) ? EXP_W'(1) : e;
    u.sig     = {(e != '0), f};
    u.is_zero = (e == '0) && (f == '0);
    u.is_inf  = (e == '1) && (f == '0);
    u.is_nan  = (e == '1) && (f != '0);
    return u;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Combinational leading-zero counter over the 14-bit working significand (14 when all zero).
module fp16_lzc (
  input  logic [13:0] sig,
  output logic [3:0]  lz
);

  always_comb begin
    lz = 4'd14;
    // Scanning upward lets the highest set bit make the final assignment.
    for (int i = 0; i < 14; i++) begin
      if (sig[i]) lz = 4'(13 - i);
    end
  end

endmodule

// File: rtl/adder_half_precision.sv
// IEEE 754 binary16 adder: unpack, align, add/subtract, normalize, round-to-nearest-even,
// registered with one cycle of latency.
module adder_half_precision
  import fp16_pkg::*;
(
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Valid,
  input  logic [15:0] i_Addend1,
  input  logic [15:0] i_Addend2,
  output logic [15:0] o_Sum,
  output logic        o_Valid
);

  fp16_unpacked_t ua, ub;
  logic        a_ge_b;
  logic        sign_l, sign_s;
  logic [4:0]  exp_l, exp_s, exp_diff;
  logic [10:0] sig_l, sig_s;
  logic [13:0] ext_l, ext_s, shifted, lost_mask, aligned;
  logic        sticky, eff_sub;
  logic [14:0] sum_raw;
  logic [3:0]  lz;
  logic [4:0]  max_shl, shl;
  logic [13:0] norm;
  logic [5:0]  exp_n, exp_f;
  logic [10:0] mant;
  logic        round_up;
  logic [11:0] mant_r;
  logic [9:0]  frac_f;
  logic [15:0] result;
  logic [15:0] sum_reg;
  logic        valid_reg;

  assign ua = fp16_unpack(i_Addend1);
  assign ub = fp16_unpack(i_Addend2);

  // Magnitude order follows directly from the {exp,frac} bit pattern.
  assign a_ge_b = i_Addend1[14:0] >= i_Addend2[14:0];
  assign sign_l = a_ge_b ? ua.sign : ub.sign;
  assign sign_s = a_ge_b ? ub.sign : ua.sign;
  assign exp_l  = a_ge_b ? ua.exp  : ub.exp;
  assign exp_s  = a_ge_b ? ub.exp  : ua.exp;
  assign sig_l  = a_ge_b ? ua.sig  : ub.sig;
  assign sig_s  = a_ge_b ? ub.sig  : ua.sig;

  assign exp_diff  = exp_l - exp_s;
  assign ext_l     = {sig_l, 3'b000};
  assign ext_s     = {sig_s, 3'b000};
  assign shifted   = ext_s >> exp_diff;
  assign lost_mask = (14'd1 << exp_diff) - 14'd1;
  assign sticky    = |(ext_s & lost_mask);
  assign aligned   = (exp_diff >= 5'd13) ? {13'd0, |sig_s}
                                         : {shifted[13:1], shifted[0] | sticky};

  assign eff_sub = sign_l ^ sign_s;
  assign sum_raw = eff_sub ? ({1'b0, ext_l} - {1'b0, aligned})
                           : ({1'b0, ext_l} + {1'b0, aligned});

  fp16_lzc u_lzc (
    .sig (sum_raw[13:0]),
    .lz  (lz)
  );

  // The left shift stops at exponent 1; anything left unnormalized is a subnormal.
  assign max_shl = exp_l - 5'd1;
  assign shl     = ({1'b0, lz} > max_shl) ? max_shl : {1'b0, lz};

  always_comb begin
    norm  = '0;
    exp_n = '0;
    if (sum_raw[14]) begin
      norm  = {sum_raw[14:2], sum_raw[1] | sum_raw[0]};
      exp_n = {1'b0, exp_l} + 6'd1;
    end else begin
      norm  = sum_raw[13:0] << shl;
      exp_n = {1'b0, exp_l} - {1'b0, shl};
    end
  end

  assign mant     = norm[13:3];
  assign round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
  assign mant_r   = {1'b0, mant} + {11'd0, round_up};

  always_comb begin
    exp_f  = '0;
    frac_f = mant_r[9:0];
    if (mant_r[11]) begin
      exp_f  = exp_n + 6'd1;
      frac_f = mant_r[10:1];
    end else if (mant_r[10]) begin
      exp_f  = exp_n;
    end
  end

  always_comb begin
    result = {sign_l, exp_f[4:0], frac_f};
    if (ua.is_nan || ub.is_nan) begin
      result = FP16_QNAN;
    end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
      result = FP16_QNAN;
    end else if (ua.is_inf) begin
      result = i_Addend1;
    end else if (ub.is_inf) begin
      result = i_Addend2;
    end else if (ua.is_zero && ub.is_zero) begin
      result = {ua.sign & ub.sign, 15'd0};
    end else if (sum_raw == '0) begin
      result = 16'h0000;
    end else if (exp_f >= 6'd31) begin
      result = sign_l ? FP16_NEG_INF : FP16_POS_INF;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sum_reg   <= 16'h0000;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= i_Valid;
      if (i_Valid) sum_reg <= result;
    end
  end

  assign o_Sum   = sum_reg;
  assign o_Valid = valid_reg;

endmodule

// File: tb/tb_adder_half_precision.sv
// Directed and randomized checks of the fp16 adder against hand-computed values and an exact integer model.
module tb_adder_half_precision;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Valid = 1'b0;
  logic [15:0] i_Addend1 = '0;
  logic [15:0] i_Addend2 = '0;
  logic [15:0] o_Sum;
  logic        o_Valid;

  int n_vectors = 0;
  int n_miscompares = 0;

  adder_half_precision dut (
    .i_Clk     (i_Clk),
    .i_Reset   (i_Reset),
    .i_Valid   (i_Valid),
    .i_Addend1 (i_Addend1),
    .i_Addend2 (i_Addend2),
    .o_Sum     (o_Sum),
    .o_Valid   (o_Valid)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic check_result(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got valid/sum=%h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: valid/sum=%h", tag, got);
    end
  endtask

  // Value scaled by 2^24 is an exact integer for every finite fp16.
  function automatic longint fp16_to_fixed(input logic [15:0] v);
    longint m;
    int e;
    e = int'(v[14:10]);
    if (e == 0) m = longint'(v[9:0]);
    else m = longint'({1'b1, v[9:0]}) <<< (e - 1);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    longint s, mag, q, rem, half;
    int p, sh, e;
    logic sgn;
    s = fp16_to_fixed(a) + fp16_to_fixed(b);
    if (s == 0) return (a[15] & b[15]) ? 16'h8000 : 16'h0000;
    sgn = (s < 0);
    mag = sgn ? -s : s;
    p = 0;
    for (int i = 0; i < 63; i++) if (mag[i]) p = i;
    sh = (p > 10) ? p - 10 : 0;
    q = mag >>> sh;
    rem = mag - (q <<< sh);
    if (sh > 0) begin
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (q == 2048) begin
      q = 1024;
      sh = sh + 1;
    end
    if (q < 1024) return {sgn, 5'd0, q[9:0]};
    e = sh + 1;
    if (e >= 31) return {sgn, 5'h1F, 10'd0};
    return {sgn, 5'(e), q[9:0]};
  endfunction

  task automatic apply(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    @(negedge i_Clk);
    i_Addend1 = a;
    i_Addend2 = b;
    i_Valid   = 1'b1;
    @(posedge i_Clk);
    #1;
    check_result(tag, {o_Valid, o_Sum}, {1'b1, exp});
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;

    repeat (2) @(posedge i_Clk);
    #1;
    check_result("reset", {o_Valid, o_Sum}, 17'h00000);
    @(negedge i_Clk);
    i_Reset = 1'b0;

    apply("one_plus_one", 16'h3C00, 16'h3C00, 16'h4000);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    @(posedge i_Clk);
    #1;
    check_result("idle_hold", {o_Valid, o_Sum}, {1'b0, 16'h4000});

    vecs.push_back('{"cancel",       16'h3C00, 16'hBC00, 16'h0000});
    vecs.push_back('{"negz_negz",    16'h8000, 16'h8000, 16'h8000});
    vecs.push_back('{"posz_negz",    16'h0000, 16'h8000, 16'h0000});
    vecs.push_back('{"tie_even",     16'h3C00, 16'h1000, 16'h3C00});
    vecs.push_back('{"tie_up",       16'h3C01, 16'h1000, 16'h3C02});
    vecs.push_back('{"above_half",   16'h3C00, 16'h1001, 16'h3C01});
    vecs.push_back('{"overflow",     16'h7BFF, 16'h7BFF, 16'h7C00});
    vecs.push_back('{"inf_m_inf",    16'h7C00, 16'hFC00, 16'h7E00});
    vecs.push_back('{"inf_p_fin",    16'h7C00, 16'h4000, 16'h7C00});
    vecs.push_back('{"fin_p_ninf",   16'h4000, 16'hFC00, 16'hFC00});
    vecs.push_back('{"nan_in",       16'h7E01, 16'h3C00, 16'h7E00});
    vecs.push_back('{"sub_sub",      16'h0001, 16'h0001, 16'h0002});
    vecs.push_back('{"sub_to_norm",  16'h03FF, 16'h0001, 16'h0400});
    vecs.push_back('{"norm_to_sub",  16'h0400, 16'h8001, 16'h03FF});
    vecs.push_back('{"zero_p_sub",   16'h0000, 16'h8155, 16'h8155});
    vecs.push_back('{"one_m_half",   16'h3C00, 16'hB800, 16'h3800});
    vecs.push_back('{"three_halves", 16'h3E00, 16'h3800, 16'h4000});
    foreach (vecs[i]) apply(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].exp);

    @(negedge i_Clk);
    i_Reset   = 1'b1;
    i_Valid   = 1'b1;
    i_Addend1 = 16'h4000;
    i_Addend2 = 16'h4000;
    @(posedge i_Clk);
    #1;
    check_result("reset_prio", {o_Valid, o_Sum}, 17'h00000);
    @(negedge i_Clk);
    i_Reset = 1'b0;

    for (int i = 0; i < 120; i++) begin
      a = 16'($urandom_range(0, 16'hFFFF));
      b = 16'($urandom_range(0, 16'hFFFF));
      if (a[14:10] == 5'h1F) a[14] = 1'b0;
      if (b[14:10] == 5'h1F) b[14] = 1'b0;
      // Near-equal exponents exercise cancellation and long normalization shifts.
      if (i % 3 == 1) b[14:10] = a[14:10];
      if (i % 3 == 2) b[14:10] = (a[14:10] == 5'd0) ? 5'd1 : a[14:10] - 5'd1;
      apply($sformatf("rand_%0d_%h_%h", i, a, b), a, b, model_add(a, b));
    end

    @(negedge i_Clk);
    i_Valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/adder_half_precision.md
Name: adder_half_precision

Overview:
Single-cycle-latency IEEE 754 binary16 (half-precision) floating-point adder for the pipeline arithmetic units. It adds two fp16 operands and registers the rounded fp16 sum. It is a leaf datapath block with no internal state beyond its output register.

Parameters:
None (format fixed: 1 sign, 5 exponent bits with bias 15, 10 fraction bits).

Ports:
i_Clk  input  1  clock; all state updates on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Valid  input  1  operands on i_Addend1/i_Addend2 are valid this cycle
i_Addend1  input  16  fp16 operand A, layout {sign[15], exp[14:10], frac[9:0]}
i_Addend2  input  16  fp16 operand B, same layout
o_Sum  output  16  registered fp16 result of A+B
o_Valid  output  1  o_Sum holds a new result

Behaviour:
- Reset: i_Reset high at a rising edge -> o_Sum=16'h0000, o_Valid=0. Reset has priority over i_Valid; an operation in flight when reset is asserted is discarded.
- Latency 1: operands sampled at edge N when i_Valid=1; o_Sum and o_Valid=1 are visible after edge N. With i_Valid=0, o_Valid=0 next cycle and o_Sum holds its previous value. No backpressure; a new operation may start every cycle.
- Datapath, combinational between input and output register:
  - Unpack. Exp=0 means zero or subnormal: implicit bit 0, effective exponent 1. Exp=31 means Inf (frac=0) or NaN (frac!=0). Otherwise implicit bit 1.
  - Swap so the larger magnitude comes first, comparing {exp,frac}.
  - Align the smaller significand right by the exponent difference. Keep guard, round and sticky bits; sticky ORs all shifted-out bits. Shifts of 13 or more collapse to sticky only.
  - Add the significands if the signs are equal, otherwise subtract (larger minus smaller). Use a 14-bit internal significand to hold the carry.
  - Normalize. On carry-out, shift right by 1 and increment the exponent. Otherwise use a leading-zero count to shift left, limited so the exponent does not go below 1; the result becomes subnormal when the limit is reached.
  - Round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalizes and increments the exponent.
  - Exponent reaching 31 after rounding -> Inf with the result sign.
- Special cases:
  - Either operand NaN -> canonical qNaN 16'h7E00.
  - +Inf + -Inf -> 16'h7E00.
  - Inf + finite -> that Inf.
- Sign of zero:
  - Exact cancellation x+(-x) -> +0 (16'h0000).
  - (-0)+(-0) -> 16'h8000; (+0)+(-0) -> 16'h0000.
  - Zero + y -> y exactly, including subnormal y.
- Subnormal results are produced, not flushed to zero. Subnormal + subnormal may carry into the normal range (exp=1).
- No exception flags are output.

Decomposition:
- Shared package fp16_pkg: field widths and positions (SIGN_BIT=15, EXP_W=5, FRAC_W=10, BIAS=15), constants FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00, FP16_NEG_INF=16'hFC00, and an unpacked-operand struct {sign, exp, sig[10:0], is_zero, is_inf, is_nan}.
- One sub-module is natural: fp16_lzc, a combinational leading-zero counter over the 14-bit significand used by normalization.
- Unpack, align, round and pack stay inline in adder_half_precision.

Test Plan:
- 16'h3C00 + 16'h3C00 (1.0+1.0) -> 16'h4000 one cycle later, o_Valid=1. Next cycle, with i_Valid=0 -> o_Valid=0 and o_Sum stays 16'h4000.
- 16'h3C00 + 16'hBC00 -> 16'h0000. Separately, 16'h8000 + 16'h8000 -> 16'h8000.
- Rounding:
  - 16'h3C00 + 16'h1000 (exact half-ulp tie) -> 16'h3C00.
  - 16'h3C01 + 16'h1000 -> 16'h3C02 (tie to even).
  - 16'h3C00 + 16'h1001 -> 16'h3C01.
- Overflow and specials:
  - 16'h7BFF + 16'h7BFF -> 16'h7C00.
  - 16'h7C00 + 16'hFC00 -> 16'h7E00.
  - 16'h7C00 + 16'h4000 -> 16'h7C00.
  - 16'h7E01 + 16'h3C00 -> 16'h7E00.
- Subnormals:
  - 16'h0001 + 16'h0001 -> 16'h0002.
  - 16'h03FF + 16'h0001 -> 16'h0400.
  - 16'h0400 + 16'h8001 -> 16'h03FF.
- Reset and random:
  - Assert i_Reset with i_Valid=1 and operands 16'h4000+16'h4000 -> next cycle o_Sum=16'h0000, o_Valid=0.
  - Random finite operands compared against a real-valued model rounded to fp16 (RNE) -> bit-exact match.
